// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer sharing one 18-bit ALU
// between two valid/ready requesters, with a registered result.
//
// Ports:
//   clk, reset          rising-edge clock, sync active-high reset
//   reqA_* / reqB_*     request channels: valid, ready, op1, op2, choice
//   rspA_* / rspB_*     response channels: valid, ready
//   result              registered ALU result, shared by both responses
//   busy                high while a result is held

module alu_share_alu #(
  parameter int W = 18
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   choice,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (choice)
      2'b00: y = a + b;
      2'b01: y = a & b;
      2'b10: y = a | b;
      2'b11: y = a ^ b;
    endcase
  end

endmodule

module alu_share_ctrl #(
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqA_valid,
  output logic              reqA_ready,
  input  logic [DATA_W-1:0] reqA_op1,
  input  logic [DATA_W-1:0] reqA_op2,
  input  logic [1:0]        reqA_choice,
  input  logic              reqB_valid,
  output logic              reqB_ready,
  input  logic [DATA_W-1:0] reqB_op1,
  input  logic [DATA_W-1:0] reqB_op2,
  input  logic [1:0]        reqB_choice,
  output logic              rspA_valid,
  input  logic              rspA_ready,
  output logic              rspB_valid,
  input  logic              rspB_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RESP = 1'b1;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  logic              state;
  logic              owner;
  logic              last_grant;
  logic [DATA_W-1:0] result_q;

  logic              grant_a;
  logic              grant_b;
  logic              idle;
  logic              accept;
  logic              rsp_done;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_choice;
  logic [DATA_W-1:0] alu_y;

  // On contention the requester that did not win last time goes.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (1'b1)
      (reqA_valid & reqB_valid): begin
        grant_a = (last_grant == OWN_B);
        grant_b = (last_grant == OWN_A);
      end
      (reqA_valid & ~reqB_valid): grant_a = 1'b1;
      (~reqA_valid & reqB_valid): grant_b = 1'b1;
      default: ;
    endcase
  end

  // Reset masks ready so nothing is accepted while it is held.
  assign idle       = (state == S_IDLE) & ~reset;
  assign reqA_ready = idle & grant_a;
  assign reqB_ready = idle & grant_b;
  assign accept     = reqA_ready | reqB_ready;

  assign rspA_valid = (state == S_RESP) & (owner == OWN_A);
  assign rspB_valid = (state == S_RESP) & (owner == OWN_B);
  assign rsp_done   = (rspA_valid & rspA_ready) |
                      (rspB_valid & rspB_ready);

  assign busy   = (state == S_RESP);
  assign result = result_q;

  always_comb begin
    alu_a      = reqA_op1;
    alu_b      = reqA_op2;
    alu_choice = reqA_choice;
    if (grant_b) begin
      alu_a      = reqB_op1;
      alu_b      = reqB_op2;
      alu_choice = reqB_choice;
    end
  end

  alu_share_alu #(
    .W (DATA_W)
  ) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .choice (alu_choice),
    .y      (alu_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      owner      <= OWN_A;
      last_grant <= OWN_B;
      result_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_RESP;
            owner      <= grant_b ? OWN_B : OWN_A;
            last_grant <= grant_b ? OWN_B : OWN_A;
            result_q   <= alu_y;
          end
        end
        S_RESP: begin
          if (rsp_done) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Arbitrating sequencer that shares one 18-bit combinational ALU (add/and/or/xor, 2-bit `choice`) between two requesters, A and B. It accepts an operation from one requester at a time using valid/ready, selects the requester round-robin, and registers the ALU result. It returns the result through a per-requester valid/ready response channel. It sits between the two client blocks and the ALU instance, which it instantiates internally.

## Interface
- `DATA_W`, default 18: operand/result width. Must equal the ALU width (18); no other value is supported.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `reqA_valid` in 1: A presents an operation.
- `reqA_ready` out 1: A's operation is accepted this cycle.
- `reqA_op1`, `reqA_op2` in 18: A's operands.
- `reqA_choice` in 2: A's opcode. 00 add, 01 and, 10 or, 11 xor.
- `reqB_valid`, `reqB_ready`, `reqB_op1`, `reqB_op2`, `reqB_choice`: same as A, for requester B.
- `rspA_valid` out 1: `result` belongs to A.
- `rspA_ready` in 1: A consumes the result.
- `rspB_valid` out 1, `rspB_ready` in 1: same as A, for requester B.
- `result` out 18: registered ALU result, shared by both response channels.
- `busy` out 1: high while a result is held (RESP state).

## Operation
- **States:** IDLE, RESP. The owner register (A/B) and the priority pointer `lastGrant` (A/B) are kept alongside the state.

- **IDLE**
  - Grant rules:
    - Only one valid: that requester is granted.
    - Both valid: the requester other than `lastGrant` is granted.
    - Neither valid: stay in IDLE.
  - `reqX_ready = (state==IDLE) & grantX`. This is combinational from `reqX_valid`.
  - Requesters must not wait for ready before raising valid. Once raised, valid and the operands are held until accepted.
  - Handshake cycle (valid & ready):
    - The granted operands and choice drive the ALU.
    - `result` is loaded with the ALU output.
    - The owner is set to the granted requester and `lastGrant` is updated to it.
    - State moves to RESP.
- **RESP**
  - `rspX_valid = (state==RESP) & (owner==X)`.
  - Both `reqX_ready` outputs are 0.
  - `result` holds its value while ready is low.
  - On `rspX_valid & rspX_ready`: move to IDLE. `result` keeps its value; only the valid flag drops.
- **Arithmetic**
  - Add is modulo 2^18: the carry is discarded and there is no overflow flag.
  - and/or/xor are bitwise.
  - All four choice codes are legal.
- **Reset** (synchronous, any state, including mid-RESP):
  - State = IDLE, `result` = 0, `lastGrant` = B (so A wins the first contention), owner = A.
  - All ready/valid outputs = 0 and `busy` = 0.
  - A pending response is discarded.
- **Simultaneous events**
  - Both valid in IDLE: round-robin as above, and exactly one ready is asserted.
  - A request arriving in the same cycle as a response handshake is not accepted until the next cycle (IDLE).

## Timing
- Accept-to-response latency is 1 cycle: the handshake at edge N gives `rspX_valid` = 1 after edge N.
- Minimum 2 cycles per operation (IDLE + RESP), so peak throughput is 1 op / 2 cycles.
- Response backpressure is unbounded: RESP holds until ready.
- With both requesters continuously valid and responses consumed immediately, grants strictly alternate.
- All outputs except `reqX_ready` are registered or decoded from state. `reqX_ready` is combinational from state, `lastGrant` and `reqX_valid`.

## Test plan
1. **Reset:** hold `reset` 2 cycles with both requesters valid → all ready/rsp valid = 0, `result` = 0x00000, `busy` = 0. Release → A granted first.
2. **A add with wrap:** A op1=0x3FFFF, op2=0x00001, choice=00 → `reqA_ready` = 1 for 1 cycle, next cycle `rspA_valid` = 1 with `result` = 0x00000. With `rspA_ready` = 1, back to IDLE one cycle later.
3. **Contention:** both valid from reset. A: 0x2AAAA and 0x3F0F0 (01). B: 0x15555 xor 0x0FFFF (11) → A served first with `result` = 0x2A0A0, then B with `result` = 0x1AAAA. `reqB_ready` = 0 throughout A's RESP.
4. **Backpressure:** B or 0x00F00 | 0x000F0 (10), `rspB_ready` held low 5 cycles while A is valid → `result` = 0x00FF0 stable, `rspB_valid` = 1, `reqA_ready` = 0 and `busy` = 1 for all 5 cycles. A accepted 1 cycle after `rspB_ready` rises.
5. **Fairness:** both valid continuously for 8 operations, responses acked immediately → grant order A,B,A,B,A,B,A,B. One accept every 2 cycles.
6. **Reset mid-RESP:** assert `reset` while `rspA_valid` = 1 → next cycle `rspA_valid` = 0, `result` = 0, state IDLE. The pending result is never delivered.
